rx_uart: RTL and testbench
==========================

RX_UART -- requirements
Module: rx_uart

Interface
REQ-001 SHALL have parameter SYSTEM_CLK, default 100_000_000, the clock frequency in Hz.
REQ-002 SHALL have parameter BAUDRATE, default 9600, the default baud rate.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 rx_in  input  1  asynchronous serial line; idle high; 8N1, LSB first.
REQ-007 div  input  16  clk cycles per symbol; 0 selects SYSTEM_CLK/BAUDRATE.
REQ-008 ready  input  1  consumer accepts the held byte.
REQ-009 rx_data  output  8  received byte holding register.
REQ-010 valid  output  1  rx_data holds an unconsumed byte.
REQ-011 frame_err  output  1  one-cycle pulse when a stop bit is sampled low.
REQ-012 overrun  output  1  one-cycle pulse when a completed byte is dropped.
REQ-013 leds  output  8  mirror of the last byte loaded into rx_data.

Function
REQ-014 SHALL pass rx_in through a 2-flop synchronizer; all logic uses the synchronized value (rxs).
REQ-015 SHALL compute CPS as (div==0 ? SYSTEM_CLK/BAUDRATE : div) and clamp it to a minimum of 4.
REQ-016 SHALL implement states IDLE, START, DATA, STOP and RECOVER, driven by one down-counter wait_cnt[15:0].
REQ-017 IDLE: when rxs is 0, SHALL load wait_cnt = (CPS>>1)-1, clear bit_idx and go to START.
REQ-018 START: when wait_cnt reaches 0, SHALL go to DATA with wait_cnt = CPS-1 if rxs is 0, else return to IDLE (glitch reject).
REQ-019 DATA: when wait_cnt reaches 0, SHALL shift rxs into shift_reg[bit_idx] and increment bit_idx.
REQ-020 DATA: after bit 7, SHALL go to STOP; otherwise SHALL reload wait_cnt = CPS-1.
REQ-021 STOP: when wait_cnt reaches 0, if rxs is 1 SHALL deliver the byte and go to IDLE.
REQ-022 STOP: when wait_cnt reaches 0, if rxs is 0 SHALL pulse frame_err, discard the byte and go to RECOVER.
REQ-023 RECOVER: SHALL stay until rxs is 1, then go to IDLE.
REQ-024 Deliver with valid=0: SHALL load rx_data and leds and set valid=1 on the next edge.
REQ-025 Deliver with valid=1 and ready=1 in the same cycle: SHALL load the new byte, keep valid=1 and not pulse overrun.
REQ-026 Deliver with valid=1 and ready=0: SHALL keep the old rx_data, pulse overrun and leave valid=1.
REQ-027 valid=1 and ready=1 with no delivery: valid SHALL be 0 on the next cycle.
REQ-028 ready while valid=0 SHALL have no effect.
REQ-029 The receiver SHALL accept a new start bit in the cycle after returning to IDLE, regardless of valid.
REQ-030 Latency: valid SHALL rise 2 (sync) + (CPS>>1) + 9*CPS + 1 cycles after the falling edge of rx_in, within ±1 cycle.
REQ-031 A change on div during a frame SHALL take effect at the next counter reload only.
REQ-032 wait_cnt arithmetic SHALL be 16-bit unsigned; no wrap-around is permitted, since reload values are at least 1.

Reset
REQ-033 While reset=1: rx_data=0, leds=0, valid=0, frame_err=0, overrun=0, state=IDLE, bit_idx=0, wait_cnt=0, synchronizer flops=1.
REQ-034 Reset asserted mid-frame SHALL abort the frame with no delivery and no pulses.
REQ-035 After reset, a line held low SHALL be treated as a start bit only after rxs is observed low in IDLE.

Structure
REQ-036 No shared package: state encodings are local constants (3-bit); CPS is computed locally.
REQ-037 No sub-module: the synchronizer, counter and FSM are in one module; target 120-250 lines of RTL.

Verification (div=16, SYSTEM_CLK irrelevant)
REQ-038 Byte 0x55 with ready held 1 -> valid high for 1 cycle, rx_data=0x55, leds=0x55, rising 155±1 cycles after the start edge.
REQ-039 rx_in low for 5 cycles, then high -> no valid and no frame_err; a following byte 0x3C is received correctly.
REQ-040 Byte 0xA3 with a low stop bit held 40 cycles -> frame_err pulse, valid stays 0; next byte 0x0F is received only after the line goes high.
REQ-041 Bytes 0x12 then 0x34 back-to-back with ready=0 -> rx_data=0x12, overrun pulse at the second stop; ready=1 for 1 cycle -> valid=0.
REQ-042 Bytes 0x12 then 0x34 with ready=1 in exactly the second delivery cycle -> rx_data=0x34, valid stays 1, no overrun.
REQ-043 Reset pulsed during bit 3 of 0x99 -> all outputs 0; the next byte 0xC5 is received with rx_data=0xC5.

Source files
------------

// File: rtl/rx_uart.sv
// rtl/rx_uart.sv - 8N1 serial receiver with a one-byte holding register and error pulses
// The synchronizer, symbol counter and framing FSM share one module.
module rx_uart #(
   parameter int SYSTEM_CLK = 100_000_000,
   parameter int BAUDRATE   = 9600
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rx_in,
   input  logic [15:0] div,
   input  logic        ready,
   output logic [7:0]  rx_data,
   output logic        valid,
   output logic        frame_err,
   output logic        overrun,
   output logic [7:0]  leds
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      START   = 3'd1,
      DATA    = 3'd2,
      STOP    = 3'd3,
      RECOVER = 3'd4
   } state_t;

   localparam int          DEF_CPS   = SYSTEM_CLK / BAUDRATE;
   localparam logic [15:0] DEF_CPS16 = DEF_CPS[15:0];

   state_t      state, state_n;
   logic        sync1, rxs;
   logic [15:0] cps_raw, cps;
   logic [15:0] wait_cnt, wait_n;
   logic [2:0]  bit_idx, bit_n;
   logic [7:0]  shift_reg, shift_n;
   logic        deliver, ferr;

   // A minimum of 4 keeps the half-symbol reload (cps>>1)-1 at 1 or more.
   assign cps_raw = (div == 16'd0) ? DEF_CPS16 : div;
   assign cps     = (cps_raw < 16'd4) ? 16'd4 : cps_raw;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1     <= 1'b1;
         rxs       <= 1'b1;
         state     <= IDLE;
         wait_cnt  <= 16'd0;
         bit_idx   <= 3'd0;
         shift_reg <= 8'd0;
      end else begin
         sync1     <= rx_in;
         rxs       <= sync1;
         state     <= state_n;
         wait_cnt  <= wait_n;
         bit_idx   <= bit_n;
         shift_reg <= shift_n;
      end
   end

   always_comb begin
      state_n = state;
      wait_n  = wait_cnt;
      bit_n   = bit_idx;
      shift_n = shift_reg;
      deliver = 1'b0;
      ferr    = 1'b0;
      case (state)
         IDLE: begin
            if (!rxs) begin
               wait_n  = (cps >> 1) - 16'd1;
               bit_n   = 3'd0;
               state_n = START;
            end
         end
         START: begin
            if (wait_cnt != 16'd0) begin
               wait_n = wait_cnt - 16'd1;
            end else if (!rxs) begin
               wait_n  = cps - 16'd1;
               state_n = DATA;
            end else begin
               state_n = IDLE;
            end
         end
         DATA: begin
            if (wait_cnt != 16'd0) begin
               wait_n = wait_cnt - 16'd1;
            end else begin
               shift_n[bit_idx] = rxs;
               bit_n            = bit_idx + 3'd1;
               wait_n           = cps - 16'd1;
               if (bit_idx == 3'd7) state_n = STOP;
            end
         end
         STOP: begin
            if (wait_cnt != 16'd0) begin
               wait_n = wait_cnt - 16'd1;
            end else if (rxs) begin
               deliver = 1'b1;
               state_n = IDLE;
            end else begin
               ferr    = 1'b1;
               state_n = RECOVER;
            end
         end
         RECOVER: begin
            if (rxs) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // A delivery with a consumer handshake in the same cycle replaces the byte instead of dropping it.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_data   <= 8'd0;
         leds      <= 8'd0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= ferr;
         overrun   <= 1'b0;
         if (deliver) begin
            if (!valid || ready) begin
               rx_data <= shift_reg;
               leds    <= shift_reg;
               valid   <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (valid && ready) begin
            valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rx_uart.sv
// tb/tb_rx_uart.sv - directed bench for rx_uart at 16 clocks per symbol
module tb_rx_uart;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rx_in = 1'b1;
   logic [15:0] div = 16'd16;
   logic        ready = 1'b1;
   logic [7:0]  rx_data, leds;
   logic        valid, frame_err, overrun;

   int checks = 0;
   int errors = 0;
   int fe_cnt = 0;
   int ov_cnt = 0;
   int vr_cnt = 0;
   logic valid_q = 1'b0;

   always #5 clk = ~clk;

   rx_uart dut (
      .clk(clk), .reset(reset), .rx_in(rx_in), .div(div), .ready(ready),
      .rx_data(rx_data), .valid(valid), .frame_err(frame_err),
      .overrun(overrun), .leds(leds)
   );

   // Counts pulse-high cycles and valid rising edges outside reset.
   always @(negedge clk) begin
      if (reset) begin
         valid_q = 1'b0;
      end else begin
         if (frame_err) fe_cnt++;
         if (overrun) ov_cnt++;
         if (valid && !valid_q) vr_cnt++;
         valid_q = valid;
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_rng(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int stop_len);
      rx_in = 1'b0;
      repeat (16) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_in = b[i];
         repeat (16) @(negedge clk);
      end
      rx_in = stop_bit;
      repeat (stop_len) @(negedge clk);
      rx_in = 1'b1;
   endtask

   task automatic wait_valid(output int lat, output logic nxt);
      logic found;
      found = 1'b0;
      lat   = 0;
      nxt   = 1'bx;
      for (int i = 0; i < 400 && !found; i++) begin
         @(posedge clk);
         #1;
         lat++;
         if (valid) found = 1'b1;
      end
      if (!found) begin
         lat = -1;
      end else begin
         @(posedge clk);
         #1;
         nxt = valid;
      end
   endtask

   task automatic recv(input logic [7:0] b, output int lat, output logic nxt);
      fork
         send_frame(b, 1'b1, 16);
         wait_valid(lat, nxt);
      join
   endtask

   typedef struct {
      logic [7:0] din;
      logic [7:0] exp_data;
      int         exp_lat;
   } vec_t;

   vec_t vecs[4];

   initial begin
      int   lat;
      logic nxt;
      int   fe0, ov0, vr0;

      vecs[0] = '{din: 8'h55, exp_data: 8'h55, exp_lat: 155};
      vecs[1] = '{din: 8'h00, exp_data: 8'h00, exp_lat: 155};
      vecs[2] = '{din: 8'hFF, exp_data: 8'hFF, exp_lat: 155};
      vecs[3] = '{din: 8'h81, exp_data: 8'h81, exp_lat: 155};

      repeat (4) @(negedge clk);
      check("rst_rx_data", rx_data, 0);
      check("rst_leds", leds, 0);
      check("rst_valid", valid, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_overrun", overrun, 0);
      reset = 1'b0;
      repeat (10) @(negedge clk);

      // Well-formed bytes with the consumer always ready.
      foreach (vecs[k]) begin
         recv(vecs[k].din, lat, nxt);
         check_rng("vec_latency", lat, vecs[k].exp_lat - 1, vecs[k].exp_lat + 1);
         check("vec_valid_one_cycle", nxt, 0);
         check("vec_rx_data", rx_data, vecs[k].exp_data);
         check("vec_leds", leds, vecs[k].exp_data);
         repeat (8) @(negedge clk);
      end

      // Start-bit glitch shorter than half a symbol.
      fe0 = fe_cnt; vr0 = vr_cnt;
      rx_in = 1'b0;
      repeat (5) @(negedge clk);
      rx_in = 1'b1;
      repeat (200) @(negedge clk);
      check("glitch_no_valid", vr_cnt, vr0);
      check("glitch_no_ferr", fe_cnt, fe0);
      recv(8'h3C, lat, nxt);
      check_rng("glitch_next_latency", lat, 154, 156);
      check("glitch_next_data", rx_data, 8'h3C);
      repeat (8) @(negedge clk);

      // Low stop bit held 40 cycles.
      fe0 = fe_cnt; vr0 = vr_cnt;
      send_frame(8'hA3, 1'b0, 40);
      check("ferr_pulse_cycles", fe_cnt, fe0 + 1);
      check("ferr_no_valid", vr_cnt, vr0);
      check("ferr_valid_low", valid, 0);
      repeat (16) @(negedge clk);
      recv(8'h0F, lat, nxt);
      check_rng("ferr_next_latency", lat, 154, 156);
      check("ferr_next_data", rx_data, 8'h0F);
      repeat (8) @(negedge clk);

      // Overrun: two bytes back to back with nobody consuming.
      ready = 1'b0;
      ov0 = ov_cnt; vr0 = vr_cnt;
      send_frame(8'h12, 1'b1, 16);
      send_frame(8'h34, 1'b1, 16);
      repeat (4) @(negedge clk);
      check("ovr_rx_data", rx_data, 8'h12);
      check("ovr_valid", valid, 1);
      check("ovr_pulse_cycles", ov_cnt, ov0 + 1);
      check("ovr_one_rise", vr_cnt, vr0 + 1);
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      check("ovr_consumed", valid, 0);
      repeat (8) @(negedge clk);

      // Consumer handshake exactly in the second delivery cycle.
      ov0 = ov_cnt;
      send_frame(8'h12, 1'b1, 16);
      check("hs_first_valid", valid, 1);
      fork
         send_frame(8'h34, 1'b1, 16);
         begin
            repeat (154) @(posedge clk);
            @(negedge clk);
            ready = 1'b1;
            @(negedge clk);
            ready = 1'b0;
         end
      join
      repeat (2) @(negedge clk);
      check("hs_rx_data", rx_data, 8'h34);
      check("hs_leds", leds, 8'h34);
      check("hs_valid", valid, 1);
      check("hs_no_overrun", ov_cnt, ov0);

      // Reset in the middle of bit 3 of 0x99.
      fe0 = fe_cnt; ov0 = ov_cnt;
      rx_in = 1'b0;
      repeat (16) @(negedge clk);
      rx_in = 1'b1; repeat (16) @(negedge clk);
      rx_in = 1'b0; repeat (16) @(negedge clk);
      rx_in = 1'b0; repeat (16) @(negedge clk);
      rx_in = 1'b1; repeat (8) @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("mid_rst_rx_data", rx_data, 0);
      check("mid_rst_leds", leds, 0);
      check("mid_rst_valid", valid, 0);
      check("mid_rst_frame_err", frame_err, 0);
      check("mid_rst_overrun", overrun, 0);
      reset = 1'b0;
      ready = 1'b1;
      repeat (40) @(negedge clk);
      check("mid_rst_no_valid", valid, 0);
      check("mid_rst_no_pulses", fe_cnt + ov_cnt, fe0 + ov0);
      recv(8'hC5, lat, nxt);
      check_rng("post_rst_latency", lat, 154, 156);
      check("post_rst_data", rx_data, 8'hC5);
      check("post_rst_leds", leds, 8'hC5);

      repeat (4) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
